mem_burst_master: RTL and testbench

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

---
 rtl/mem_burst_pkg.sv | 17 +
 rtl/mem_burst_rdbuf.sv | 38 +++
 rtl/mem_burst_master.sv | 178 +++++++++++++++++
 tb/tb_mem_burst_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared types and constants for the burst memory master.
// Optional feature macro: MEM_BURST_TIMEOUT_EN (read-wait timeout abort).
package mem_burst_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_CYC = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_burst_rdbuf.sv
// mem_burst_rdbuf: one-entry valid/ready holding register for read beats.
// Data captured on i_load stays stable until the consumer takes it.
module mem_burst_rdbuf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Capture a beat when empty, release it on the valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
    end else begin
      if (i_load && !r_valid) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: single-port memory burst master with host command,
// write-beat and read-beat streams.
// Optional feature macro: MEM_BURST_TIMEOUT_EN -- when defined, a read that
// waits TIMEOUT_CYC cycles without mem_valid aborts with a sticky err flag.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_cmd_ready;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_wr_beat;
  logic              w_rd_load;
  logic              w_rd_hs;
  logic              w_last;
  logic              w_to_expire;
  logic              w_rd_valid;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_cnt_dec;

  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_wr_beat  = (r_state == ST_WR) & wr_valid;
  assign w_rd_load  = (r_state == ST_RD_WAIT) & mem_valid;
  assign w_rd_hs    = (r_state == ST_RD_OUT) & w_rd_valid & rd_ready;
  assign w_last     = (r_cnt == {ADDR_W{1'b0}});
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_cnt_dec  = r_cnt - ADDR_W'(1);

`ifdef MEM_BURST_TIMEOUT_EN
  logic [4:0] r_to_cnt;

  // Count consecutive RD_WAIT cycles without a memory response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 5'd0;
    end else if ((r_state == ST_RD_WAIT) && !mem_valid) begin
      r_to_cnt <= r_to_cnt + 5'd1;
    end else begin
      r_to_cnt <= 5'd0;
    end
  end

  assign w_to_expire = (r_state == ST_RD_WAIT) & ~mem_valid &
                       (r_to_cnt == 5'(TIMEOUT_CYC - 1));
`else
  assign w_to_expire = 1'b0;
`endif

  // Burst sequencer: command accept, beat counting, done/err generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= {ADDR_W{1'b0}};
      r_cnt       <= {ADDR_W{1'b0}};
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= cmd_addr;
            r_cnt       <= cmd_len;
            r_cmd_ready <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= cmd_rw ? ST_RD_REQ : ST_WR;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_WR: begin
          if (w_wr_beat) begin
            r_addr <= w_addr_inc;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              r_cnt <= w_cnt_dec;
            end
          end else begin
            r_state <= ST_WR;
          end
        end
        ST_RD_REQ: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_rd_load) begin
            r_state <= ST_RD_OUT;
          end else if (w_to_expire) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_cmd_ready <= 1'b1;
          end else begin
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_OUT: begin
          if (w_rd_hs) begin
            r_addr <= w_addr_inc;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_dec;
              r_state <= ST_RD_REQ;
            end
          end else begin
            r_state <= ST_RD_OUT;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  mem_burst_rdbuf #(
    .DATA_W (DATA_W)
  ) u_rdbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rd_load),
    .i_data  (mem_rdata),
    .i_ready (rd_ready),
    .o_data  (rd_data),
    .o_valid (w_rd_valid)
  );

  // Memory is written on every rw=0 cycle, so rw drops only on a real beat;
  // it is decoded from the state register, so reset forces it high at once.
  assign mem_rw    = ~w_wr_beat;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_wr_beat ? wr_data : {DATA_W{1'b0}};
  assign wr_ready  = (r_state == ST_WR);
  assign rd_valid  = w_rd_valid;
  assign cmd_ready = r_cmd_ready;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master (default ADDR_W=4, DATA_W=8).
// Honours MEM_BURST_TIMEOUT_EN for the read-timeout scenario.
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       mem_rw;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_valid, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tb_mem  [16];
  logic [7:0] ref_mem [16];
  logic [7:0] wbuf    [16];
  logic [3:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  logic [7:0] rlog   [$];
  int spurious = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Memory: combinational read, write on every clock with rw=0.
  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_rw === 1'b0) begin
      tb_mem[mem_addr] <= mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
      if (wr_valid !== 1'b1) spurious <= spurious + 1;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic issue_cmd(input logic rw, input logic [3:0] a, input logic [3:0] l);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = l;
        ok = 1'b1;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready never high, required high within 50 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random gaps
  task automatic drive_write(input int nb, input int mode);
    int idx;
    bit v;
    idx = 0;
    for (int c = 0; c < 400 && idx < nb; c++) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      wr_valid = v;
      wr_data  = wbuf[idx];
      if (v && wr_ready === 1'b1) idx++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = 8'h00;
  endtask

  task automatic drive_read(input int nb, input int stall_beat, input int stall_cyc,
                            input bit rnd, input bit poke, output int viol);
    int got;
    int left;
    bit holding;
    bit r;
    logic [7:0] hd;
    logic [3:0] ha;
    got = 0; left = stall_cyc; holding = 1'b0; viol = 0; hd = 8'h00; ha = 4'h0;
    for (int c = 0; c < 800 && got < nb; c++) begin
      @(negedge clk);
      mem_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid === 1'b1 && got == stall_beat && left > 0) begin
        if (!holding) begin
          hd = rd_data; ha = mem_addr; holding = 1'b1;
        end else if (rd_data !== hd || mem_addr !== ha) begin
          viol++;
        end
        r = 1'b0;
        left--;
        cmd_valid = poke;
        cmd_rw    = 1'b0;
      end else begin
        cmd_valid = 1'b0;
      end
      rd_ready = r;
      if (rd_valid === 1'b1 && r) begin
        rlog.push_back(rd_data);
        got++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0; mem_valid = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
    wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0; mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, mem_rw, mem_addr, mem_wdata, rd_data, rd_valid, wr_ready, busy, done, err}
        !== {1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b rw=%b addr=%h wd=%h rd=%h rv=%b wrdy=%b busy=%b done=%b err=%b, required 0 1 0 00 00 0 0 0 0 0",
               cmd_ready, mem_rw, mem_addr, mem_wdata, rd_data, rd_valid, wr_ready, busy, done, err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  // Shared check of a finished write burst against the arithmetic model.
  task automatic test_write(input string nm, input logic [3:0] a, input logic [3:0] l, input int mode);
    int s, d0, sp0, nb;
    logic [3:0] ea;
    nb = int'(l) + 1;
    for (int i = 0; i < nb; i++) wbuf[i] = (nm == "write_full") ? 8'(i) : 8'($urandom);
    s = wlog_a.size(); d0 = done_cnt; sp0 = spurious;
    issue_cmd(1'b0, a, l);
    drive_write(nb, mode);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wlog_a.size() - s != nb) begin
      n_fail++;
      $display("FAIL %s_count: %0d write cycles, required %0d", nm, wlog_a.size() - s, nb);
    end
    for (int i = 0; i < nb && s + i < wlog_a.size(); i++) begin
      ea = a + 4'(i);
      n_checks++;
      if (wlog_a[s + i] !== ea || wlog_d[s + i] !== wbuf[i]) begin
        n_fail++;
        $display("FAIL %s_beat%0d: addr=%h data=%h, required addr=%h data=%h",
                 nm, i, wlog_a[s + i], wlog_d[s + i], ea, wbuf[i]);
      end
    end
    for (int i = 0; i < nb; i++) ref_mem[a + 4'(i)] = wbuf[i];
    n_checks++;
    if (spurious - sp0 != 0 || done_cnt - d0 != 1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: spurious=%0d done_pulses=%0d busy=%b rdy=%b, required 0 1 0 1",
               nm, spurious - sp0, done_cnt - d0, busy, cmd_ready);
    end
  endtask

  task automatic test_read(input string nm, input logic [3:0] a, input logic [3:0] l,
                           input int stall_beat, input bit rnd, input bit spec_data);
    int rs, s, d0, nb, viol;
    logic [7:0] ed;
    nb = int'(l) + 1;
    rs = rlog.size(); s = wlog_a.size(); d0 = done_cnt;
    issue_cmd(1'b1, a, l);
    drive_read(nb, stall_beat, 5, rnd, stall_beat >= 0, viol);
    repeat (2) @(negedge clk);
    n_checks++;
    if (rlog.size() - rs != nb) begin
      n_fail++;
      $display("FAIL %s_count: %0d beats, required %0d", nm, rlog.size() - rs, nb);
    end
    for (int i = 0; i < nb && rs + i < rlog.size(); i++) begin
      ed = spec_data ? 8'(4'(a + 4'(i))) : ref_mem[a + 4'(i)];
      n_checks++;
      if (rlog[rs + i] !== ed) begin
        n_fail++;
        $display("FAIL %s_beat%0d: rd_data=%h, required %h", nm, i, rlog[rs + i], ed);
      end
    end
    n_checks++;
    if (viol != 0 || wlog_a.size() != s || done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: stall_changes=%0d writes=%0d done_pulses=%0d busy=%b, required 0 0 1 0",
               nm, viol, wlog_a.size() - s, done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int s, d0;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
    s = wlog_a.size(); d0 = done_cnt;
    issue_cmd(1'b0, 4'h3, 4'h7);
    drive_write(2, 0);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = wbuf[2];
    #1;
    n_checks++;
    if (mem_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_beat3_live: mem_rw=%b, required 0", mem_rw);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_rw !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: mem_rw=%b busy=%b wr_ready=%b, required 1 0 0", mem_rw, busy, wr_ready);
    end
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) ref_mem[4'h3 + 4'(i)] = wbuf[i];
    n_checks++;
    if (wlog_a.size() - s != 2 || done_cnt != d0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after: writes=%0d done_pulses=%0d rdy=%b, required 2 0 1",
               wlog_a.size() - s, done_cnt - d0, cmd_ready);
    end
    test_write("post_rst_write", 4'h3, 4'h7, 0);
  endtask

  task automatic test_random();
    logic [3:0] a, l;
    for (int k = 0; k < 6; k++) begin
      a = 4'($urandom); l = 4'($urandom);
      test_write("rnd_write", a, l, 2);
      a = 4'($urandom); l = 4'($urandom);
      test_read("rnd_read", a, l, -1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    mem_valid = 1'b0;
`ifdef MEM_BURST_TIMEOUT_EN
    begin
      int bc;
      issue_cmd(1'b1, 4'h5, 4'h0);
      bc = 0;
      for (int c = 0; c < 60; c++) begin
        if (busy !== 1'b1) break;
        bc++;
        @(negedge clk);
      end
      n_checks++;
      if (bc != 17 || err !== 1'b1 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_abort: busy_cycles=%0d err=%b done=%b, required 17 1 1", bc, err, done);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || done !== 1'b0 || done_cnt - d0 != 1) begin
        n_fail++;
        $display("FAIL timeout_sticky: err=%b done=%b pulses=%0d, required 1 0 1", err, done, done_cnt - d0);
      end
      issue_cmd(1'b0, 4'h9, 4'h0);
      n_checks++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_clear: err=%b after new command, required 0", err);
      end
      wbuf[0] = 8'hA5;
      drive_write(1, 0);
      ref_mem[9] = 8'hA5;
      repeat (2) @(negedge clk);
    end
`else
    issue_cmd(1'b1, 4'h5, 4'h0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: busy=%b err=%b pulses=%0d, required 1 0 0", busy, err, done_cnt - d0);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL no_timeout_recover: busy=%b rdy=%b pulses=%0d, required 0 1 0", busy, cmd_ready, done_cnt - d0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write("write_full", 4'h0, 4'hF, 0);
    test_read("read_wrap", 4'hE, 4'h3, -1, 1'b0, 1'b1);
    test_read("read_stall", 4'h2, 4'h3, 1, 1'b0, 1'b0);
    test_write("write_gapped", 4'h6, 4'hF, 1);
    test_reset_mid_burst();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
